// File: rtl/sbh_cg_scheduler_if.sv
// Bundle of every non-clock signal between the CG scheduler and its
// surroundings: TU control, coefficient memory read port, NZ-finder
// datapath, per-CG result handshake and status.
// master = the scheduler, slave = the environment driving it.
interface sbh_cg_scheduler_if #(
    parameter int COEFF_W = 16
);
    // TU control
    logic                      start;
    logic [4:0]                num_cg;
    // Coefficient memory read port
    logic                      mem_rd_en;
    logic [7:0]                mem_addr;
    logic signed [COEFF_W-1:0] mem_rdata;
    // NZ-finder datapath, load side
    logic                      dp_valid_in;
    logic signed [COEFF_W-1:0] dp_coef;
    logic [3:0]                dp_position;
    logic                      dp_load_done;
    // NZ-finder datapath, result side
    logic [3:0]                dp_firstNZ;
    logic [3:0]                dp_lastNZ;
    logic                      dp_hasNZ;
    logic                      dp_valid_out;
    // Per-CG result handshake
    logic                      res_valid;
    logic                      res_ready;
    logic [3:0]                res_cg_idx;
    logic [3:0]                res_firstNZ;
    logic [3:0]                res_lastNZ;
    logic                      res_sbh_en;
    // Status
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        input  start, num_cg, mem_rdata,
               dp_firstNZ, dp_lastNZ, dp_hasNZ, dp_valid_out,
               res_ready,
        output mem_rd_en, mem_addr,
               dp_valid_in, dp_coef, dp_position, dp_load_done,
               res_valid, res_cg_idx, res_firstNZ, res_lastNZ, res_sbh_en,
               busy, done, err
    );

    modport slave (
        output start, num_cg, mem_rdata,
               dp_firstNZ, dp_lastNZ, dp_hasNZ, dp_valid_out,
               res_ready,
        input  mem_rd_en, mem_addr,
               dp_valid_in, dp_coef, dp_position, dp_load_done,
               res_valid, res_cg_idx, res_firstNZ, res_lastNZ, res_sbh_en,
               busy, done, err
    );
endinterface

// File: rtl/sbh_cg_scheduler.sv
// Sign-bit-hiding coefficient-group scheduler.
// For each CG of a transform unit it streams CG_SIZE coefficients from the
// coefficient memory into the NZ-finder datapath, waits (bounded) for the
// datapath's first/last nonzero positions, and presents one result per CG
// on a valid/ready handshake together with the sign-hiding decision.
// All outputs are registered except dp_coef, which forwards the memory
// read data in the cycle it is valid (zero otherwise).
module sbh_cg_scheduler #(
    parameter int COEFF_W    = 16,
    parameter int CG_SIZE    = 16,
    parameter int SBH_THRESH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sbh_cg_scheduler_if.master   bus
);

    localparam int         TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [3:0] K_LAST = 4'(CG_SIZE - 1);
    localparam logic [4:0] MAX_CG = 5'd16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        LDONE,
        WAIT,
        RESULT
    } state_t;

    state_t              state_q;
    logic [4:0]          num_cg_q;
    logic [3:0]          cg_idx_q;
    logic [3:0]          k_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                mem_rd_en_q;
    logic [7:0]          mem_addr_q;
    logic                dp_valid_in_q;
    logic [3:0]          dp_position_q;
    logic                dp_load_done_q;
    logic                res_valid_q;
    logic [3:0]          res_cg_idx_q;
    logic [3:0]          res_firstNZ_q;
    logic [3:0]          res_lastNZ_q;
    logic                res_sbh_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    // Combinational helpers feeding the state register
    logic [4:0]          num_cg_sat_d;
    logic [3:0]          nz_span_d;
    logic                sbh_en_d;
    logic                last_cg_d;
    logic [3:0]          cg_next_d;

    // Linear coefficient address of scan position k inside CG cg.
    function automatic logic [7:0] addr_of(input logic [3:0] cg, input logic [3:0] k);
        return 8'(int'(cg) * CG_SIZE + int'(k));
    endfunction

    // Requested CG count clamped to the 16 CGs a TU can hold; the span is a
    // 4-bit wrap-around difference, and a CG with no nonzero never hides a sign.
    always_comb begin
        num_cg_sat_d = (bus.num_cg > MAX_CG) ? MAX_CG : bus.num_cg;
        nz_span_d    = bus.dp_lastNZ - bus.dp_firstNZ;
        sbh_en_d     = bus.dp_hasNZ && (int'(nz_span_d) >= SBH_THRESH);
        last_cg_d    = (({1'b0, cg_idx_q} + 5'd1) == num_cg_q);
        cg_next_d    = cg_idx_q + 4'd1;
    end

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            num_cg_q       <= '0;
            cg_idx_q       <= '0;
            k_q            <= '0;
            tmo_q          <= '0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            dp_valid_in_q  <= 1'b0;
            dp_position_q  <= '0;
            dp_load_done_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_cg_idx_q   <= '0;
            res_firstNZ_q  <= '0;
            res_lastNZ_q   <= '0;
            res_sbh_en_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            // Pulses default low; the datapath write strobe trails the read
            // strobe by the one-cycle memory latency, carrying the read's k.
            done_q         <= 1'b0;
            dp_load_done_q <= 1'b0;
            dp_valid_in_q  <= mem_rd_en_q;
            if (mem_rd_en_q) begin
                dp_position_q <= k_q;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_cg_q <= num_cg_sat_d;
                        cg_idx_q <= '0;
                        k_q      <= '0;
                        err_q    <= 1'b0;
                        if (num_cg_sat_d == 5'd0) begin
                            // Empty TU: acknowledge immediately, never go busy.
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            busy_q      <= 1'b1;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= addr_of(4'd0, 4'd0);
                        end
                    end
                end

                FETCH: begin
                    // k_q names the address currently on the bus.
                    if (k_q == K_LAST) begin
                        mem_rd_en_q <= 1'b0;
                        state_q     <= DRAIN;
                    end else begin
                        k_q        <= k_q + 4'd1;
                        mem_addr_q <= addr_of(cg_idx_q, k_q + 4'd1);
                    end
                end

                DRAIN: begin
                    // Final coefficient is being written this cycle.
                    dp_load_done_q <= 1'b1;
                    state_q        <= LDONE;
                end

                LDONE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (bus.dp_valid_out) begin
                        res_valid_q   <= 1'b1;
                        res_cg_idx_q  <= cg_idx_q;
                        res_firstNZ_q <= bus.dp_firstNZ;
                        res_lastNZ_q  <= bus.dp_lastNZ;
                        res_sbh_en_q  <= sbh_en_d;
                        state_q       <= RESULT;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // Datapath stalled: abandon the whole TU.
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                RESULT: begin
                    // res_* stay frozen until the consumer takes them.
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (last_cg_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cg_idx_q    <= cg_next_d;
                            k_q         <= '0;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= addr_of(cg_next_d, 4'd0);
                            state_q     <= FETCH;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output drive; the coefficient is forwarded only while it is valid.
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.dp_valid_in  = dp_valid_in_q;
    assign bus.dp_coef      = dp_valid_in_q ? bus.mem_rdata : '0;
    assign bus.dp_position  = dp_position_q;
    assign bus.dp_load_done = dp_load_done_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_cg_idx   = res_cg_idx_q;
    assign bus.res_firstNZ  = res_firstNZ_q;
    assign bus.res_lastNZ   = res_lastNZ_q;
    assign bus.res_sbh_en   = res_sbh_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_sbh_cg_scheduler.sv
// Testbench for sbh_cg_scheduler: coefficient memory and a one-cycle
// NZ-finder datapath are modelled here; single-CG scan patterns come from a
// vector table, multi-CG, stall, timeout, saturation and reset cases are
// hand-written sequences.
module tb_sbh_cg_scheduler;

    localparam int COEFF_W    = 16;
    localparam int CG_SIZE    = 16;
    localparam int SBH_THRESH = 4;
    localparam int TIMEOUT    = 8;
    // Negedges from the start cycle to res_valid: start + 16 FETCH + DRAIN + LDONE + WAIT
    localparam int LAT        = 20;
    // Negedges from start to the timeout done: 18 load cycles + start + 8 WAIT
    localparam int TMO_LAT    = 27;
    // 16 CGs back to back, each accepted the cycle after res_valid
    localparam int SAT_LAT    = 321;
    localparam int NV         = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sbh_cg_scheduler_if #(.COEFF_W(COEFF_W)) bus ();

    sbh_cg_scheduler #(
        .COEFF_W   (COEFF_W),
        .CG_SIZE   (CG_SIZE),
        .SBH_THRESH(SBH_THRESH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- coefficient memory model ----------------
    logic signed [COEFF_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic signed [COEFF_W-1:0] cval(input int i);
        return (i % 2 == 1) ? COEFF_W'(-(i + 1)) : COEFF_W'(i * 3 + 1);
    endfunction

    // ---------------- NZ-finder datapath model ----------------
    bit         dp_respond = 1'b1;
    bit         dp_spur    = 1'b0;
    logic [3:0] acc_first, acc_last, out_first, out_last;
    logic       acc_has, out_has, dp_vo_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_first <= 4'hF; acc_last <= 4'hF; acc_has <= 1'b0;
            out_first <= 4'h0; out_last <= 4'h0; out_has <= 1'b0;
            dp_vo_q   <= 1'b0;
        end else begin
            dp_vo_q <= 1'b0;
            if (bus.dp_valid_in && bus.dp_coef != 0) begin
                if (!acc_has) acc_first <= bus.dp_position;
                acc_last <= bus.dp_position;
                acc_has  <= 1'b1;
            end
            if (bus.dp_load_done) begin
                if (dp_respond) begin
                    dp_vo_q   <= 1'b1;
                    out_first <= acc_first;
                    out_last  <= acc_last;
                    out_has   <= acc_has;
                end
                acc_first <= 4'hF; acc_last <= 4'hF; acc_has <= 1'b0;
            end
        end
    end

    assign bus.dp_firstNZ   = out_first;
    assign bus.dp_lastNZ    = out_last;
    assign bus.dp_hasNZ     = out_has;
    assign bus.dp_valid_out = dp_vo_q | dp_spur;

    // ---------------- monitor ----------------
    int   done_cnt = 0, rv_rise = 0, rd_cnt = 0, beat = 0;
    int   addr_hits [256];
    logic rv_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            beat    = 0;
            rv_prev = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.res_valid && !rv_prev) rv_rise++;
            rv_prev = bus.res_valid;
            if (bus.mem_rd_en) begin
                rd_cnt++;
                addr_hits[bus.mem_addr]++;
            end
            if (bus.dp_valid_in) begin
                check("dp_position", 64'(bus.dp_position), 64'(beat));
                beat++;
            end
            if (bus.dp_load_done) begin
                check("load_beats", 64'(beat), 64'(CG_SIZE));
                beat = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] all_outs();
        return 64'({bus.mem_rd_en, bus.mem_addr, bus.dp_valid_in, bus.dp_coef,
                    bus.dp_position, bus.dp_load_done, bus.res_valid, bus.res_cg_idx,
                    bus.res_firstNZ, bus.res_lastNZ, bus.res_sbh_en,
                    bus.busy, bus.done, bus.err});
    endfunction

    function automatic logic sig_now(input int which);
        return (which == 0) ? bus.res_valid : bus.done;
    endfunction

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic start_tu(input logic [4:0] ncg);
        bus.start  = 1'b1;
        bus.num_cg = ncg;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // which: 0 = res_valid, 1 = done. n counts negedges, starting at base.
    task automatic wait_sig(input int which, input int base, input int lim, output int n);
        n = base;
        while (!sig_now(which) && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic int bad_addrs(input int upto);
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (addr_hits[a] != ((a < upto) ? 1 : 0)) bad++;
        end
        return bad;
    endfunction

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [15:0] mask;   // scan positions holding a nonzero coefficient
        logic [3:0]  first;
        logic [3:0]  last;
        logic        sbh;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int n;
        int done0, rv0, rd0;
        int base;
        logic [3:0] a_first [3];
        logic [3:0] a_last  [3];
        logic       a_sbh   [3];

        vecs[0] = '{mask: 16'h0204, first: 4'd2,  last: 4'd9,  sbh: 1'b1}; // span 7
        vecs[1] = '{mask: 16'h0000, first: 4'd15, last: 4'd15, sbh: 1'b0}; // all zero
        vecs[2] = '{mask: 16'h0048, first: 4'd3,  last: 4'd6,  sbh: 1'b0}; // span 3
        vecs[3] = '{mask: 16'h0011, first: 4'd0,  last: 4'd4,  sbh: 1'b1}; // span 4 == thresh
        vecs[4] = '{mask: 16'h0020, first: 4'd5,  last: 4'd5,  sbh: 1'b0}; // single NZ
        vecs[5] = '{mask: 16'h8001, first: 4'd0,  last: 4'd15, sbh: 1'b1}; // full span
        vecs[6] = '{mask: 16'h2012, first: 4'd1,  last: 4'd13, sbh: 1'b1}; // interior NZ ignored

        for (int i = 0; i < 256; i++) begin
            mem[i]       = '0;
            addr_hits[i] = 0;
        end
        bus.start     = 1'b0;
        bus.num_cg    = 5'd0;
        bus.res_ready = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 64'd0);

        // ---- single-CG vectors ----
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) mem[i] = vecs[v].mask[i] ? cval(i) : '0;
            bus.res_ready = 1'b1;
            start_tu(5'd1);
            wait_sig(0, 1, 200, n);
            check($sformatf("v%0d_latency", v), 64'(n), 64'(LAT));
            check($sformatf("v%0d_cg_idx", v), 64'(bus.res_cg_idx), 64'd0);
            check($sformatf("v%0d_firstNZ", v), 64'(bus.res_firstNZ), 64'(vecs[v].first));
            check($sformatf("v%0d_lastNZ", v), 64'(bus.res_lastNZ), 64'(vecs[v].last));
            check($sformatf("v%0d_sbh_en", v), 64'(bus.res_sbh_en), 64'(vecs[v].sbh));
            check($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), 64'({bus.done, bus.res_valid, bus.busy}), 64'b100);
            @(negedge clk);
            check($sformatf("v%0d_done_end", v), 64'(bus.done), 64'd0);
        end

        // ---- three CGs, consumer stalls 5 cycles each ----
        for (int i = 0; i < 256; i++) begin
            mem[i]       = '0;
            addr_hits[i] = 0;
        end
        mem[1]  = cval(1);  mem[12] = cval(12);   // CG0: 1..12
        mem[23] = cval(7);                        // CG1: 7 only
        mem[32] = cval(0);  mem[46] = cval(14);   // CG2: 0..14
        a_first[0] = 4'd1; a_last[0] = 4'd12; a_sbh[0] = 1'b1;
        a_first[1] = 4'd7; a_last[1] = 4'd7;  a_sbh[1] = 1'b0;
        a_first[2] = 4'd0; a_last[2] = 4'd14; a_sbh[2] = 1'b1;
        done0 = done_cnt; rd0 = rd_cnt;
        bus.res_ready = 1'b0;
        start_tu(5'd3);
        base = 1;
        for (int c = 0; c < 3; c++) begin
            wait_sig(0, base, 200, n);
            check($sformatf("cg%0d_latency", c), 64'(n), 64'(LAT));
            for (int s = 0; s < 5; s++) begin
                check($sformatf("cg%0d_stall%0d", c, s),
                      64'({bus.res_valid, bus.res_cg_idx, bus.res_firstNZ, bus.res_lastNZ, bus.res_sbh_en}),
                      64'({1'b1, 4'(c), a_first[c], a_last[c], a_sbh[c]}));
                if (c == 0) begin
                    bus.start  = (s == 1);   // must be ignored while busy
                    bus.num_cg = 5'd1;
                end
                @(negedge clk);
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            check($sformatf("cg%0d_valid_drop", c), 64'(bus.res_valid), 64'd0);
            if (c < 2) begin
                check($sformatf("cg%0d_no_done", c), 64'(bus.done), 64'd0);
                dp_spur = 1'b1;               // stray result strobe during FETCH
                @(negedge clk);
                dp_spur = 1'b0;
                base = 2;
            end else begin
                check("multi_done_pulse", 64'(bus.done), 64'd1);
            end
        end
        repeat (3) @(negedge clk);
        check("multi_done_count", 64'(done_cnt - done0), 64'd1);
        check("multi_reads", 64'(rd_cnt - rd0), 64'd48);
        check("multi_addr_once", 64'(bad_addrs(48)), 64'd0);

        // ---- datapath timeout ----
        for (int i = 0; i < 256; i++) mem[i] = '0;
        dp_respond    = 1'b0;
        bus.res_ready = 1'b1;
        rv0 = rv_rise; rd0 = rd_cnt;
        start_tu(5'd2);
        wait_sig(1, 1, 200, n);
        check("tmo_latency", 64'(n), 64'(TMO_LAT));
        check("tmo_state", 64'({bus.err, bus.busy, bus.res_valid}), 64'b100);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 64'({bus.err, bus.done}), 64'b10);
        check("tmo_no_result", 64'(rv_rise - rv0), 64'd0);
        check("tmo_reads", 64'(rd_cnt - rd0), 64'd16);
        dp_respond = 1'b1;
        start_tu(5'd0);
        check("tmo_err_clear", 64'({bus.err, bus.done, bus.busy}), 64'b010);

        // ---- num_cg saturation: 20 -> 16 CGs ----
        for (int i = 0; i < 256; i++) addr_hits[i] = 0;
        rv0 = rv_rise;
        @(negedge clk);
        start_tu(5'd20);
        wait_sig(1, 1, 1000, n);
        check("sat_latency", 64'(n), 64'(SAT_LAT));
        check("sat_last_cg", 64'(bus.res_cg_idx), 64'd15);
        check("sat_results", 64'(rv_rise - rv0), 64'd16);
        check("sat_addr_once", 64'(bad_addrs(256)), 64'd0);

        // ---- reset during FETCH of CG1 of 4 ----
        @(negedge clk);
        start_tu(5'd4);
        wait_sig(0, 1, 200, n);
        check("rst_cg0_latency", 64'(n), 64'(LAT));
        n = 0;
        while (!(bus.mem_rd_en && bus.mem_addr == 8'd21) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_cg1", 64'({bus.mem_rd_en, bus.mem_addr}), 64'({1'b1, 8'd21}));
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        done0 = done_cnt; rv0 = rv_rise; rd0 = rd_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_activity", 64'({32'(done_cnt - done0), 16'(rv_rise - rv0), 16'(rd_cnt - rd0)}), 64'd0);
        check("rst_idle_outs", all_outs(), 64'd0);
        start_tu(5'd0);
        check("rst_empty_done", 64'({bus.done, bus.busy, bus.mem_rd_en, bus.res_valid}), 64'b1000);
        @(negedge clk);
        check("rst_empty_end", all_outs(), 64'd0);
        check("rst_empty_no_reads", 64'(rd_cnt - rd0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sbh_cg_scheduler.md
SBH_CG_SCHEDULER -- requirements
Module: sbh_cg_scheduler

Interface
REQ-001 SHALL have parameter COEFF_W, default 16, coefficient width in bits.
REQ-002 SHALL have parameter CG_SIZE, default 16, coefficients per coefficient group (CG).
REQ-003 SHALL have parameter SBH_THRESH, default 4, minimum lastNZ-firstNZ distance enabling sign hiding.
REQ-004 SHALL have parameter TIMEOUT, default 8, cycles allowed for a datapath result.
REQ-005 Ports (name, direction, width, meaning); one clock, reset asynchronous and active-low:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin scheduling a transform unit (TU); sampled in IDLE only
- num_cg  in  5  CG count for the TU, 0..16; sampled with start
- mem_rd_en  out  1  coefficient memory read strobe
- mem_addr  out  8  read address = cg_idx*CG_SIZE + k
- mem_rdata  in  COEFF_W  signed read data, valid exactly 1 cycle after mem_rd_en
- dp_valid_in  out  1  coefficient write strobe to the CG NZ-finder datapath
- dp_coef  out  COEFF_W  coefficient to datapath
- dp_position  out  4  scan position of dp_coef
- dp_load_done  out  1  one-cycle pulse: CG load complete
- dp_firstNZ, dp_lastNZ  in  4 each  datapath result positions
- dp_hasNZ  in  1  datapath: CG has a nonzero coefficient
- dp_valid_out  in  1  datapath result strobe (one cycle)
- res_valid  out  1  per-CG result valid
- res_ready  in  1  consumer accepts result
- res_cg_idx  out  4  CG index of result
- res_firstNZ, res_lastNZ  out  4 each  registered copies of datapath result
- res_sbh_en  out  1  sign hiding enabled for this CG
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at TU end
- err  out  1  sticky timeout flag, cleared only by the next accepted start

Function
REQ-006 FSM states SHALL be IDLE, FETCH, DRAIN, LDONE, WAIT, RESULT.
REQ-007 IDLE: start=1 SHALL latch num_cg, clear cg_idx, k and err; num_cg=0 -> remain IDLE and pulse done next cycle; else -> FETCH.
REQ-008 FETCH SHALL assert mem_rd_en for CG_SIZE consecutive cycles, k=0..15, mem_addr={cg_idx,k}; after k=15 -> DRAIN.
REQ-009 dp_valid_in, dp_coef=mem_rdata, dp_position=k SHALL follow each mem_rd_en by exactly 1 cycle (position registered, coefficient passed from memory).
REQ-010 DRAIN (1 cycle) carries the last dp_valid_in (k=15); -> LDONE.
REQ-011 LDONE (1 cycle) SHALL assert dp_load_done=1 with dp_valid_in=0; -> WAIT with timeout counter cleared.
REQ-012 WAIT: dp_valid_out=1 SHALL register dp_firstNZ/lastNZ/hasNZ into res_* and go to RESULT; counter reaching TIMEOUT with no dp_valid_out SHALL set err, pulse done, return to IDLE.
REQ-013 res_sbh_en SHALL equal dp_hasNZ AND (dp_lastNZ - dp_firstNZ, 4-bit unsigned) >= SBH_THRESH; hasNZ=0 -> res_sbh_en=0 regardless of positions.
REQ-014 RESULT: res_valid held 1 with stable res_* until res_valid AND res_ready; on that cycle res_valid drops next cycle; last CG (cg_idx=num_cg-1) -> IDLE with done pulse, else cg_idx+1 -> FETCH.
REQ-015 Per-CG latency with res_ready=1 and a 1-cycle datapath: 16 FETCH + DRAIN + LDONE + WAIT cycles to first res_valid.
REQ-016 start while busy=1 SHALL be ignored; dp_valid_out outside WAIT SHALL be ignored.
REQ-017 num_cg>16 SHALL be saturated to 16.

Reset
REQ-018 rst_n=0 at any time SHALL force IDLE immediately; all outputs 0 (mem_addr, dp_coef, dp_position, res_* included), cg_idx/k/counters 0, err 0.
REQ-019 Reset mid-TU SHALL discard the TU; no done pulse, no res_valid after rst_n rises until a new start.

Verification
REQ-020 Bench SHALL cover: num_cg=1, CG0 nonzero only at scan 2 and 9, res_ready=1 -> res_firstNZ=2, res_lastNZ=9, res_sbh_en=1, done pulse.
REQ-021 Bench SHALL cover: all-zero CG -> res_hasNZ path, res_firstNZ=15, res_lastNZ=15, res_sbh_en=0.
REQ-022 Bench SHALL cover: num_cg=3, res_ready low 5 cycles per CG -> res_* stable while stalled, res_cg_idx 0,1,2 in order, mem_addr 0..47 each once, one done.
REQ-023 Bench SHALL cover: datapath never returns dp_valid_out -> err=1 after TIMEOUT WAIT cycles, done pulse, IDLE.
REQ-024 Bench SHALL cover: rst_n low during FETCH of CG1 of 4 -> all outputs 0, no done, next start=1 num_cg=0 -> done pulse only.
REQ-025 Bench SHALL cover: positions 3 and 6 nonzero -> difference 3 < SBH_THRESH -> res_sbh_en=0.
